// File: rtl/tpx3_data_framer.sv
// Timepix3 readout framer: one-register FWFT pass-through stage that interleaves
// {MARK_ID, SEQ, WCNT} marker words every MARK_INTERVAL data words or after an idle gap.
module tpx3_data_framer #(
   parameter int unsigned MARK_INTERVAL = 1024,
   parameter int unsigned IDLE_TIMEOUT  = 4000,
   parameter logic [3:0]  MARK_ID       = 4'hF
) (
   input  logic        BUS_CLK,
   input  logic        BUS_RST_N,
   input  logic        ENABLE,
   input  logic        IN_EMPTY,
   input  logic [31:0] IN_DATA,
   output logic        IN_READ,
   input  logic        OUT_READ,
   output logic        OUT_EMPTY,
   output logic [31:0] OUT_DATA,
   output logic [15:0] MARK_COUNT
);

   localparam logic [15:0] INTERVAL_C = 16'(MARK_INTERVAL);
   localparam logic [15:0] TIMEOUT_C  = 16'(IDLE_TIMEOUT);

   typedef enum logic {
      ST_PASS = 1'b0,
      ST_MARK = 1'b1
   } state_t;

   function automatic logic [31:0] build_marker(input logic [11:0] seq, input logic [15:0] wcnt);
      return {MARK_ID, seq, wcnt};
   endfunction

   state_t      state_q, state_d;
   logic        ovalid_q, ovalid_d;
   logic [31:0] data_q, data_d;
   logic [15:0] wcnt_q, wcnt_d;
   logic [15:0] idle_q, idle_d;
   logic [11:0] seq_q, seq_d;
   logic [15:0] mcnt_q, mcnt_d;
   logic        slot_free_s;
   logic        in_read_s;

   // The reset term keeps the pop strobe low while the async reset is held.
   assign slot_free_s = !ovalid_q || OUT_READ;
   assign in_read_s   = BUS_RST_N && !IN_EMPTY && slot_free_s && (state_q == ST_PASS);

   // Next-state logic for the output slot, counters and PASS/MARK sequencing.
   always_comb begin
      state_d  = state_q;
      ovalid_d = ovalid_q;
      data_d   = data_q;
      wcnt_d   = wcnt_q;
      idle_d   = idle_q;
      seq_d    = seq_q;
      mcnt_d   = mcnt_q;
      case (state_q)
         ST_PASS: begin
            if (in_read_s) begin
               data_d   = IN_DATA;
               ovalid_d = 1'b1;
               idle_d   = 16'd0;
               if (ENABLE) begin
                  wcnt_d = wcnt_q + 16'd1;
                  if (wcnt_d == INTERVAL_C) begin
                     state_d = ST_MARK;
                  end else begin
                     state_d = ST_PASS;
                  end
               end else begin
                  wcnt_d = 16'd0;
               end
            end else begin
               if (slot_free_s) begin
                  ovalid_d = 1'b0;
               end else begin
                  ovalid_d = ovalid_q;
               end
               if (!ENABLE) begin
                  wcnt_d = 16'd0;
                  idle_d = 16'd0;
               end else if (wcnt_q != 16'd0) begin
                  // Idle saturates at the timeout; it is cleared by the flush marker.
                  if (idle_q >= TIMEOUT_C) begin
                     state_d = ST_MARK;
                  end else begin
                     idle_d = idle_q + 16'd1;
                  end
               end else begin
                  idle_d = idle_q;
               end
            end
         end
         ST_MARK: begin
            if (slot_free_s) begin
               data_d   = build_marker(seq_q, wcnt_q);
               ovalid_d = 1'b1;
               wcnt_d   = 16'd0;
               idle_d   = 16'd0;
               seq_d    = seq_q + 12'd1;
               mcnt_d   = mcnt_q + 16'd1;
               state_d  = ST_PASS;
            end else begin
               state_d = ST_MARK;
            end
         end
         default: begin
            state_d = ST_PASS;
         end
      endcase
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         state_q  <= ST_PASS;
         ovalid_q <= 1'b0;
         data_q   <= 32'd0;
         wcnt_q   <= 16'd0;
         idle_q   <= 16'd0;
         seq_q    <= 12'd0;
         mcnt_q   <= 16'd0;
      end else begin
         state_q  <= state_d;
         ovalid_q <= ovalid_d;
         data_q   <= data_d;
         wcnt_q   <= wcnt_d;
         idle_q   <= idle_d;
         seq_q    <= seq_d;
         mcnt_q   <= mcnt_d;
      end
   end

   assign IN_READ    = in_read_s;
   assign OUT_EMPTY  = !ovalid_q;
   assign OUT_DATA   = data_q;
   assign MARK_COUNT = mcnt_q;

endmodule

// File: tb/tb_tpx3_data_framer.sv
// Scoreboard bench for tpx3_data_framer with MARK_INTERVAL=4, IDLE_TIMEOUT=8.
module tb_tpx3_data_framer;

   logic        BUS_CLK = 1'b0;
   logic        BUS_RST_N;
   logic        ENABLE;
   logic        IN_EMPTY;
   logic [31:0] IN_DATA;
   logic        IN_READ;
   logic        OUT_READ;
   logic        OUT_EMPTY;
   logic [31:0] OUT_DATA;
   logic [15:0] MARK_COUNT;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_pop_cyc = 0;
   int last_obs_cyc = 0;
   int rd_low = 0;
   logic [31:0] src_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];

   tpx3_data_framer #(
      .MARK_INTERVAL(4),
      .IDLE_TIMEOUT (8),
      .MARK_ID      (4'hF)
   ) dut (
      .BUS_CLK   (BUS_CLK),
      .BUS_RST_N (BUS_RST_N),
      .ENABLE    (ENABLE),
      .IN_EMPTY  (IN_EMPTY),
      .IN_DATA   (IN_DATA),
      .IN_READ   (IN_READ),
      .OUT_READ  (OUT_READ),
      .OUT_EMPTY (OUT_EMPTY),
      .OUT_DATA  (OUT_DATA),
      .MARK_COUNT(MARK_COUNT)
   );

   always #5 BUS_CLK = ~BUS_CLK;

   task automatic set_src();
      IN_EMPTY = (src_q.size() == 0);
      IN_DATA  = (src_q.size() == 0) ? 32'h0 : src_q[0];
   endtask

   // One cycle: sample at negedge, pop the FWFT source just after posedge.
   task automatic tick();
      logic rd;
      @(negedge BUS_CLK);
      rd = IN_READ;
      if (!IN_EMPTY && !IN_READ) rd_low++;
      if (OUT_READ && !OUT_EMPTY) begin
         obs_q.push_back(OUT_DATA);
         last_obs_cyc = cyc;
      end
      if (rd) last_pop_cyc = cyc;
      @(posedge BUS_CLK);
      #1;
      if (rd && src_q.size() > 0) src_q.delete(0);
      cyc++;
      set_src();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (obs_q.size() < exp_q.size() && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      BUS_RST_N = 1'b1;
      ENABLE    = 1'b1;
      OUT_READ  = 1'b1;
      IN_EMPTY  = 1'b0;
      IN_DATA   = 32'hDEAD_BEEF;
      #1;
      BUS_RST_N = 1'b0;
      #1;
      checks++;
      if (OUT_EMPTY !== 1'b1) begin errors++; $display("FAIL reset_out_empty got %b want 1", OUT_EMPTY); end
      checks++;
      if (IN_READ !== 1'b0) begin errors++; $display("FAIL reset_in_read got %b want 0", IN_READ); end
      checks++;
      if (MARK_COUNT !== 16'h0) begin errors++; $display("FAIL reset_mark_count got %h want 0000", MARK_COUNT); end
      checks++;
      if (OUT_DATA !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 00000000", OUT_DATA); end
      src_q.delete();
      set_src();
      @(posedge BUS_CLK);
      #1;
      BUS_RST_N = 1'b1;
   endtask

   task automatic test_interval();
      obs_q.delete();
      exp_q.delete();
      for (int i = 1; i <= 5; i++) src_q.push_back(32'(i));
      exp_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'hF000_0004, 32'h5};
      rd_low = 0;
      set_src();
      drain(40);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL interval_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size()) begin errors++; $display("FAIL interval_word[%0d] got none want %h", i, exp_q[i]); end
         else if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL interval_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      checks++;
      if (rd_low !== 1) begin errors++; $display("FAIL interval_read_gap got %0d want 1", rd_low); end
      checks++;
      if (MARK_COUNT !== 16'd1) begin errors++; $display("FAIL interval_mark_count got %0d want 1", MARK_COUNT); end
   endtask

   task automatic test_idle_flush();
      int gap;
      obs_q.delete();
      exp_q.delete();
      src_q.push_back(32'h6);
      src_q.push_back(32'h7);
      exp_q = '{32'h6, 32'h7, 32'hF001_0003};
      set_src();
      drain(60);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL idle_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size()) begin errors++; $display("FAIL idle_word[%0d] got none want %h", i, exp_q[i]); end
         else if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL idle_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      gap = last_obs_cyc - last_pop_cyc;
      checks++;
      if (gap < 9 || gap > 12) begin errors++; $display("FAIL idle_latency got %0d want 9..12", gap); end
      checks++;
      if (MARK_COUNT !== 16'd2) begin errors++; $display("FAIL idle_mark_count got %0d want 2", MARK_COUNT); end
   endtask

   task automatic test_back_pressure();
      int n = 0;
      int bad = 0;
      obs_q.delete();
      exp_q.delete();
      for (int i = 0; i < 10; i++) src_q.push_back(32'h10 + 32'(i));
      exp_q = '{32'h10, 32'h11, 32'h12, 32'h13, 32'hF002_0004,
                32'h14, 32'h15, 32'h16, 32'h17, 32'hF003_0004,
                32'h18, 32'h19, 32'hF004_0002};
      set_src();
      while (src_q.size() > 6 && n < 20) begin
         tick();
         n++;
      end
      OUT_READ = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge BUS_CLK);
         checks++;
         if (OUT_DATA !== 32'h13 || IN_READ !== 1'b0 || OUT_EMPTY !== 1'b0) begin
            bad++;
            errors++;
            $display("FAIL stall_hold[%0d] got data=%h in_read=%b empty=%b want data=00000013 in_read=0 empty=0",
                     i, OUT_DATA, IN_READ, OUT_EMPTY);
         end
         @(posedge BUS_CLK);
         #1;
         cyc++;
      end
      OUT_READ = 1'b1;
      drain(80);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size()) begin errors++; $display("FAIL bp_word[%0d] got none want %h", i, exp_q[i]); end
         else if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      checks++;
      if (MARK_COUNT !== 16'd5) begin errors++; $display("FAIL bp_mark_count got %0d want 5", MARK_COUNT); end
   endtask

   task automatic test_pass_through();
      obs_q.delete();
      exp_q.delete();
      ENABLE = 1'b0;
      for (int i = 0; i < 10; i++) begin
         src_q.push_back(32'hA0 + 32'(i));
         exp_q.push_back(32'hA0 + 32'(i));
      end
      set_src();
      drain(40);
      repeat (20) tick();
      checks++;
      if (obs_q.size() !== 10) begin errors++; $display("FAIL pass_count got %0d want 10", obs_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size()) begin errors++; $display("FAIL pass_word[%0d] got none want %h", i, exp_q[i]); end
         else if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL pass_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      checks++;
      if (MARK_COUNT !== 16'd5) begin errors++; $display("FAIL pass_mark_count got %0d want 5", MARK_COUNT); end
      ENABLE = 1'b1;
   endtask

   task automatic test_reset_mid_stream();
      obs_q.delete();
      exp_q.delete();
      OUT_READ = 1'b0;
      src_q.push_back(32'h55);
      src_q.push_back(32'h66);
      set_src();
      tick();
      #2;
      BUS_RST_N = 1'b0;
      #1;
      checks++;
      if (OUT_EMPTY !== 1'b1 || OUT_DATA !== 32'h0) begin
         errors++;
         $display("FAIL midrst_out got empty=%b data=%h want empty=1 data=00000000", OUT_EMPTY, OUT_DATA);
      end
      checks++;
      if (IN_READ !== 1'b0) begin errors++; $display("FAIL midrst_in_read got %b want 0", IN_READ); end
      checks++;
      if (MARK_COUNT !== 16'h0) begin errors++; $display("FAIL midrst_mark_count got %h want 0000", MARK_COUNT); end
      src_q.delete();
      set_src();
      @(posedge BUS_CLK);
      #1;
      BUS_RST_N = 1'b1;
      OUT_READ  = 1'b1;
      src_q.push_back(32'h77);
      set_src();
      obs_q.delete();
      rd_low = 0;
      tick();
      checks++;
      if (src_q.size() !== 0 || rd_low !== 0) begin
         errors++;
         $display("FAIL first_pop got left=%0d stalls=%0d want left=0 stalls=0", src_q.size(), rd_low);
      end
      exp_q = '{32'h77, 32'hF000_0001};
      drain(40);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL midrst_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size()) begin errors++; $display("FAIL midrst_word[%0d] got none want %h", i, exp_q[i]); end
         else if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_word[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      checks++;
      if (MARK_COUNT !== 16'd1) begin errors++; $display("FAIL midrst_mark_count got %0d want 1", MARK_COUNT); end
   endtask

   // SEQ starts at 1 here (one marker since the last reset); 4095 more wraps it.
   task automatic test_wrap();
      logic [11:0] seq = 12'h001;
      logic [31:0] w;
      for (int phase = 0; phase < 2; phase++) begin
         obs_q.delete();
         exp_q.delete();
         for (int g = 0; g < ((phase == 0) ? 4095 : 1); g++) begin
            for (int k = 0; k < 4; k++) begin
               w = $urandom;
               src_q.push_back(w);
               exp_q.push_back(w);
            end
            exp_q.push_back({4'hF, seq, 16'h0004});
            seq = seq + 12'd1;
         end
         set_src();
         drain(2 * exp_q.size() + 40);
         checks++;
         if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL wrap%0d_count got %0d want %0d", phase, obs_q.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size()) begin errors++; $display("FAIL wrap%0d_word[%0d] got none want %h", phase, i, exp_q[i]); end
            else if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap%0d_word[%0d] got %h want %h", phase, i, obs_q[i], exp_q[i]); end
         end
         checks++;
         if (MARK_COUNT !== ((phase == 0) ? 16'h1000 : 16'h1001)) begin
            errors++;
            $display("FAIL wrap%0d_mark_count got %h want %h", phase, MARK_COUNT, (phase == 0) ? 16'h1000 : 16'h1001);
         end
      end
   endtask

   initial begin
      test_reset();
      test_interval();
      test_idle_flush();
      test_back_pressure();
      test_pass_through();
      test_reset_mid_stream();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got time=%0t want completion", $time);
      $fatal(1, "bench time limit exceeded");
   end

endmodule

// File: doc/tpx3_data_framer.md
TPX3_DATA_FRAMER -- requirements
Module: tpx3_data_framer

Interface
REQ-001 Parameter MARK_INTERVAL, default 1024: data words between markers; the legal range SHALL be 1..65535.
REQ-002 Parameter IDLE_TIMEOUT, default 4000: idle cycles before a flush marker; the value SHALL be >= 1.
REQ-003 Parameter MARK_ID, default 4'hF: marker identifier nibble.
REQ-004 BUS_CLK  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-005 BUS_RST_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 ENABLE  input  1  SHALL enable marker insertion; low means pure pass-through.
REQ-007 IN_EMPTY  input  1  SHALL be the upstream (arbiter) empty flag; IN_DATA is valid whenever it is low (first-word fall-through).
REQ-008 IN_DATA  input  32  SHALL be the upstream data word.
REQ-009 IN_READ  output  1  SHALL pop one upstream word per cycle it is high.
REQ-010 OUT_READ  input  1  SHALL be the downstream (bram_fifo) pop strobe.
REQ-011 OUT_EMPTY  output  1  SHALL be low while OUT_DATA holds a valid word.
REQ-012 OUT_DATA  output  32  SHALL be the registered output word.
REQ-013 MARK_COUNT  output  16  SHALL count emitted markers, wrapping 0xFFFF->0.

Function
REQ-014 The output SHALL be a single register, OVALID, with OUT_EMPTY = !OVALID; slot_free = !OVALID | OUT_READ.
REQ-015 OUT_READ while OUT_EMPTY=1 SHALL be ignored: no state change, no error.
REQ-016 FSM states SHALL be PASS and MARK; the reset state is PASS.
REQ-017 IN_READ SHALL equal !IN_EMPTY & slot_free & (state==PASS), combinationally.
REQ-018 A word popped via IN_READ SHALL appear on OUT_DATA the next cycle, unmodified, giving a latency of 1 cycle.
REQ-019 Throughput SHALL be 1 word/cycle when OUT_READ is held high.
REQ-020 When slot_free=1 and no load occurs, OVALID SHALL be cleared.
REQ-021 WCNT (16 bit) SHALL increment on each IN_READ while ENABLE=1.
REQ-022 When IN_READ accepts the word that makes WCNT == MARK_INTERVAL, the FSM SHALL enter MARK on that same edge.
REQ-023 IDLE (16 bit) SHALL increment each cycle that ENABLE=1, state==PASS, IN_READ=0 and WCNT != 0.
REQ-024 IDLE SHALL clear on any IN_READ and on marker load.
REQ-025 When IDLE reaches IDLE_TIMEOUT, the FSM SHALL enter MARK on the next edge (flush).
REQ-026 In MARK, on the first cycle with slot_free=1, the output register SHALL load the marker.
REQ-027 Marker format: [31:28]=MARK_ID, [27:16]=SEQ, [15:0]=WCNT.
REQ-028 On the same edge as the marker load, WCNT<=0, IDLE<=0, SEQ<=SEQ+1, MARK_COUNT<=MARK_COUNT+1, and state<=PASS.
REQ-029 SEQ SHALL be 12 bits and wrap 0xFFF->0x000.
REQ-030 No upstream word SHALL be accepted in MARK; a marker SHALL never be dropped or duplicated; back-pressure SHALL stall the FSM indefinitely.
REQ-031 With ENABLE=0, WCNT and IDLE SHALL be held at 0 and no new MARK entry SHALL occur.
REQ-032 If already in MARK when ENABLE falls, the pending marker SHALL still be emitted.
REQ-033 With WCNT=0, no idle marker SHALL be generated, so an empty stream emits nothing.

Reset
REQ-034 While BUS_RST_N=0, the following SHALL be forced asynchronously: OVALID=0 (OUT_EMPTY=1), OUT_DATA=0, IN_READ=0, state=PASS, WCNT=IDLE=SEQ=0, MARK_COUNT=0.
REQ-035 Reset asserted mid-stream SHALL discard any held word or pending marker.
REQ-036 The first IN_READ SHALL be possible on the first rising edge after deassertion.

Verification (MARK_INTERVAL=4, IDLE_TIMEOUT=8, MARK_ID=F)
REQ-037 Reset check: pulse BUS_RST_N low -> OUT_EMPTY=1, IN_READ=0, MARK_COUNT=0, with no clock edge required.
REQ-038 Interval marker: words 0x1..0x5 with ENABLE=1, OUT_READ=1 -> OUT sequence 0x1, 0x2, 0x3, 0x4, 0xF0000004, 0x5; IN_READ is low for exactly 1 cycle; MARK_COUNT=1.
REQ-039 Idle flush: after REQ-038, words 0x6, 0x7, then IN_EMPTY=1 -> 0xF0010003 appears 8 idle cycles after 0x7 is popped (WCNT=3 includes 0x5); MARK_COUNT=2.
REQ-040 Back-pressure: OUT_READ=0 for 10 cycles mid-stream, with marker due -> OUT_DATA is stable, IN_READ=0 throughout; on release the order is preserved with no loss or duplication.
REQ-041 Pass-through: ENABLE=0, 10 words 0xA0..0xA9 -> identical output, no markers, MARK_COUNT unchanged.
REQ-042 Wrap: force 4096 markers -> SEQ field returns to 0x000 and MARK_COUNT=0x1000.
